arith_logic_unit: RTL and testbench
===================================

# arith_logic_unit

Registered 16-bit arithmetic/logic execution unit: signed add and subtract with overflow detection, plus bitwise AND and NOR. It sits in the execute stage of the datapath, alongside the packed-byte adder and the shifter. It produces a result and the zero/negative/overflow condition flags one clock after an operation is issued.

## Interface
- Parameters: none (width fixed at 16 bits).
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `in_valid`  input  1  operation issue strobe; operands and opcode sampled when high.
- `alu_op`  input  3  opcode: 3'd0 ADD, 3'd2 SUB, 3'd3 AND, 3'd4 NOR; all other codes illegal.
- `src0`  input  16  first operand (two's complement for ADD/SUB).
- `src1`  input  16  second operand (two's complement for ADD/SUB).
- `out_valid`  output  1  result/flags updated this cycle.
- `result`  output  16  registered result.
- `zr`  output  1  result equals 0x0000.
- `neg`  output  1  negative flag.
- `ov`  output  1  signed overflow flag.
- `illegal_op`  output  1  issued opcode was not a supported code.

## Operation
- ADD: src0 + src1, 16-bit two's complement.
- SUB: src0 − src1, computed as src0 + ~src1 + 1.
- Overflow:
  - ADD overflows when the operand signs are equal and the raw sum sign differs from them.
  - SUB overflows when src0 and src1 signs differ and the raw difference sign differs from src0.
  - src1 = 0x8000 is covered by this rule; no special case.
- Saturation (see Configuration):
  - Positive overflow → 0x7FFF.
  - Negative overflow → 0x8000.
- ADD/SUB flags:
  - `ov` = overflow detected.
  - `neg` = bit 15 of the final (post-saturation) result.
  - `zr` = final result == 0.
- AND: src0 & src1. NOR: ~(src0 | src1).
- AND/NOR flags: `zr` = result == 0; `neg` = 0; `ov` = 0.
- Illegal opcode:
  - result = 0x0000, `zr` = 0, `neg` = 0, `ov` = 0, `illegal_op` = 1.
  - `out_valid` still asserts.
- `illegal_op` = 0 for all legal operations.

## Timing
- Latency is 1 cycle: an op sampled at edge N has result/flags visible after edge N, with `out_valid` = 1 for that cycle.
- Throughput is one op per cycle; back-to-back issues produce back-to-back results. No stall or backpressure.
- `in_valid` low at an edge:
  - `out_valid` = 0 next cycle.
  - result, flags and `illegal_op` hold their previous values.
- Reset (`rst_n` low at an edge):
  - result = 0x0000, `zr` = 0, `neg` = 0, `ov` = 0, `illegal_op` = 0, `out_valid` = 0.
  - Reset overrides a simultaneous `in_valid`; the in-flight op is discarded.
- Operand and opcode inputs are ignored while `in_valid` = 0.

## Configuration
- `ALU_SATURATE_EN` defined: ADD/SUB results saturate on overflow as described; `ov` still reports the overflow.
- `ALU_SATURATE_EN` undefined:
  - ADD/SUB return the wrapped 16-bit result.
  - `ov` is unchanged.
  - `neg`/`zr` reflect the wrapped result.
- AND/NOR are unaffected in both builds.

## Test plan
- ADD 0x7FFF + 0x0001 → with macro: result 0x7FFF, ov=1, neg=0, zr=0; without macro: 0x8000, ov=1, neg=1.
- ADD 0x8000 + 0xFFFF → with macro: 0x8000, ov=1, neg=1; without macro: 0x7FFF, ov=1, neg=0.
- SUB 0x0005 − 0x0005 → 0x0000, zr=1, neg=0, ov=0. SUB 0x0003 − 0x0005 → 0xFFFE, neg=1, ov=0.
- AND 0xF0F0 & 0x0FF0 → 0x00F0, zr=0. NOR 0xFFFF, 0x0000 → 0x0000, zr=1, neg=0, ov=0.
- alu_op=3'd6 with `in_valid`=1 → result 0x0000, illegal_op=1, all flags 0, out_valid=1. Next cycle `in_valid`=0 → out_valid=0, outputs held.
- Issue ADD 1+1 with `rst_n`=0 on the same edge → all outputs 0 and out_valid=0. Back-to-back ADD 1+2 then AND 0x00FF&0x0F0F → 0x0003 then 0x000F on consecutive cycles.

Source files
------------

// File: rtl/arith_logic_unit.sv
// arith_logic_unit: registered 16-bit execute-stage ALU.
// Operations: signed ADD/SUB with overflow detection, bitwise AND and NOR.
// Result and zr/neg/ov/illegal_op flags appear one clock after issue.
// Optional build macro ALU_SATURATE_EN: when defined, ADD/SUB clamp to
// 0x7FFF / 0x8000 on overflow; when undefined they return the wrapped sum.
module arith_logic_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [2:0]  alu_op,
    input  logic [15:0] src0,
    input  logic [15:0] src1,
    output logic        out_valid,
    output logic [15:0] result,
    output logic        zr,
    output logic        neg,
    output logic        ov,
    output logic        illegal_op
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd4;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    logic        out_valid_q, out_valid_d;
    logic [15:0] result_q, result_d;
    logic        zr_q, zr_d;
    logic        neg_q, neg_d;
    logic        ov_q, ov_d;
    logic        illegal_op_q, illegal_op_d;

    logic [15:0] sum_raw;
    logic [15:0] diff_raw;
    logic        add_ovf;
    logic        sub_ovf;

    // Raw adder/subtractor and their signed-overflow detection.
    always_comb begin
        sum_raw  = src0 + src1;
        diff_raw = src0 + ~src1 + 16'd1;
        add_ovf  = (src0[15] == src1[15]) && (sum_raw[15] != src0[15]);
        sub_ovf  = (src0[15] != src1[15]) && (diff_raw[15] != src0[15]);
    end

    // Next-state selection: hold everything when idle, else compute the op.
    always_comb begin
        out_valid_d  = 1'b0;
        result_d     = result_q;
        zr_d         = zr_q;
        neg_d        = neg_q;
        ov_d         = ov_q;
        illegal_op_d = illegal_op_q;

        if (in_valid) begin
            out_valid_d  = 1'b1;
            illegal_op_d = 1'b0;
            case (alu_op)
                OP_ADD, OP_SUB: begin
                    ov_d     = (alu_op == OP_ADD) ? add_ovf : sub_ovf;
                    result_d = (alu_op == OP_ADD) ? sum_raw : diff_raw;
`ifdef ALU_SATURATE_EN
                    // On overflow the true result's sign follows src0 for
                    // both ADD and SUB, so src0[15] picks the clamp value.
                    if (ov_d) begin
                        result_d = src0[15] ? SAT_NEG : SAT_POS;
                    end
`endif
                    neg_d = result_d[15];
                    zr_d  = (result_d == 16'h0000);
                end
                OP_AND: begin
                    result_d = src0 & src1;
                    zr_d     = (result_d == 16'h0000);
                    neg_d    = 1'b0;
                    ov_d     = 1'b0;
                end
                OP_NOR: begin
                    result_d = ~(src0 | src1);
                    zr_d     = (result_d == 16'h0000);
                    neg_d    = 1'b0;
                    ov_d     = 1'b0;
                end
                default: begin
                    result_d     = 16'h0000;
                    zr_d         = 1'b0;
                    neg_d        = 1'b0;
                    ov_d         = 1'b0;
                    illegal_op_d = 1'b1;
                end
            endcase
        end
    end

    // Output registers with synchronous active-low reset; reset wins over issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            result_q     <= 16'h0000;
            zr_q         <= 1'b0;
            neg_q        <= 1'b0;
            ov_q         <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            zr_q         <= zr_d;
            neg_q        <= neg_d;
            ov_q         <= ov_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zr         = zr_q;
    assign neg        = neg_q;
    assign ov         = ov_q;
    assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_arith_logic_unit.sv
// tb_arith_logic_unit: directed + randomized check of arith_logic_unit
// against an integer-arithmetic reference model. Follows ALU_SATURATE_EN.
module tb_arith_logic_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  alu_op;
    logic [15:0] src0;
    logic [15:0] src1;
    logic        out_valid;
    logic [15:0] result;
    logic        zr;
    logic        neg;
    logic        ov;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    // Reference-model state (what the outputs should show right now).
    logic        e_vld;
    logic [15:0] e_res;
    logic        e_zr;
    logic        e_neg;
    logic        e_ov;
    logic        e_ill;

    arith_logic_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .alu_op     (alu_op),
        .src0       (src0),
        .src1       (src1),
        .out_valid  (out_valid),
        .result     (result),
        .zr         (zr),
        .neg        (neg),
        .ov         (ov),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    // Behavioural model: signed integer arithmetic with range test for overflow.
    task automatic model_step(input logic rst, input logic v, input logic [2:0] op,
                              input logic [15:0] a, input logic [15:0] b);
        int s;
        logic [15:0] r;
        if (rst) begin
            e_vld = 0; e_res = 0; e_zr = 0; e_neg = 0; e_ov = 0; e_ill = 0;
        end else if (!v) begin
            e_vld = 0;
        end else begin
            e_vld = 1;
            e_ill = 0;
            case (op)
                3'd0, 3'd2: begin
                    if (op == 3'd0) s = int'($signed(a)) + int'($signed(b));
                    else            s = int'($signed(a)) - int'($signed(b));
                    e_ov = (s > 32767) || (s < -32768);
`ifdef ALU_SATURATE_EN
                    if (s > 32767)       r = 16'h7FFF;
                    else if (s < -32768) r = 16'h8000;
                    else                 r = s[15:0];
`else
                    r = s[15:0];
`endif
                    e_res = r;
                    e_neg = ($signed(r) < 0);
                    e_zr  = (r == 0);
                end
                3'd3, 3'd4: begin
                    r = (op == 3'd3) ? (a & b) : ~(a | b);
                    e_res = r; e_zr = (r == 0); e_neg = 0; e_ov = 0;
                end
                default: begin
                    e_res = 0; e_zr = 0; e_neg = 0; e_ov = 0; e_ill = 1;
                end
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"},  {15'd0, out_valid},  {15'd0, e_vld});
        check({tag, ".result"},     result,              e_res);
        check({tag, ".zr"},         {15'd0, zr},         {15'd0, e_zr});
        check({tag, ".neg"},        {15'd0, neg},        {15'd0, e_neg});
        check({tag, ".ov"},         {15'd0, ov},         {15'd0, e_ov});
        check({tag, ".illegal_op"}, {15'd0, illegal_op}, {15'd0, e_ill});
    endtask

    // Drive one cycle, update model, sample #1 after the edge, report one line.
    task automatic issue(input string tag, input logic rst, input logic v,
                         input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        rst_n = ~rst; in_valid = v; alu_op = op; src0 = a; src1 = b;
        @(posedge clk);
        #1;
        model_step(rst, v, op, a, b);
        check_all(tag);
        $display("%s rst=%0b v=%0b op=%0d a=%h b=%h -> ov_valid=%0b res=%h zr=%0b neg=%0b ov=%0b ill=%0b",
                 tag, rst, v, op, a, b, out_valid, result, zr, neg, ov, illegal_op);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 6))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'hFFFF;
            4: return 16'h0001;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        rst_n = 0; in_valid = 0; alu_op = 0; src0 = 0; src1 = 0;
        model_step(1, 0, 0, 0, 0);
        @(posedge clk);
        issue("reset", 1, 0, 3'd0, 16'h0, 16'h0);

        // Directed cases from the plan, with literal expectations where fixed.
        issue("add_pos_ovf", 0, 1, 3'd0, 16'h7FFF, 16'h0001);
`ifdef ALU_SATURATE_EN
        check("tp_add_pos_ovf", result, 16'h7FFF);
`else
        check("tp_add_pos_ovf", result, 16'h8000);
`endif
        check("tp_add_pos_ovf.ov", {15'd0, ov}, 16'd1);
        issue("add_neg_ovf", 0, 1, 3'd0, 16'h8000, 16'hFFFF);
`ifdef ALU_SATURATE_EN
        check("tp_add_neg_ovf", result, 16'h8000);
`else
        check("tp_add_neg_ovf", result, 16'h7FFF);
`endif
        issue("sub_zero", 0, 1, 3'd2, 16'h0005, 16'h0005);
        check("tp_sub_zero.zr", {15'd0, zr}, 16'd1);
        issue("sub_neg", 0, 1, 3'd2, 16'h0003, 16'h0005);
        check("tp_sub_neg", result, 16'hFFFE);
        issue("sub_min", 0, 1, 3'd2, 16'h0000, 16'h8000);
        issue("and", 0, 1, 3'd3, 16'hF0F0, 16'h0FF0);
        check("tp_and", result, 16'h00F0);
        issue("and_msb", 0, 1, 3'd3, 16'h8000, 16'hFFFF);
        issue("nor", 0, 1, 3'd4, 16'hFFFF, 16'h0000);
        check("tp_nor.zr", {15'd0, zr}, 16'd1);
        issue("illegal", 0, 1, 3'd6, 16'h1234, 16'h5678);
        check("tp_illegal", {15'd0, illegal_op}, 16'd1);
        issue("idle_hold", 0, 0, 3'd0, 16'hAAAA, 16'h5555);
        issue("add_reset", 1, 1, 3'd0, 16'h0001, 16'h0001);
        check("tp_add_reset", result, 16'h0000);
        issue("b2b_add", 0, 1, 3'd0, 16'h0001, 16'h0002);
        check("tp_b2b_add", result, 16'h0003);
        issue("b2b_and", 0, 1, 3'd3, 16'h00FF, 16'h0F0F);
        check("tp_b2b_and", result, 16'h000F);

        // Randomized traffic, including idle cycles and occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic r, v;
            logic [2:0] op;
            r  = ($urandom_range(0, 49) == 0);
            v  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 4) == 0) ? 3'($urandom()) : 3'($urandom_range(0, 4));
            issue($sformatf("rnd%0d", i), r, v, op, pick(), pick());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
